// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between the CPU
// memory path and a debug/loader port; one access in flight at a time.
module ram_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_r_en,
   output logic              ram_w_en,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              r_en_q, r_en_d;
   logic              w_en_q, w_en_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              dbg_ack_q, dbg_ack_d;
   logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
   logic [DATA_W-1:0] dbg_rd_q, dbg_rd_d;
   logic              gnt_dbg;

   // On a tie the requester opposite the last owner wins
   assign gnt_dbg = dbg_req & (~cpu_req | ~owner_q);

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      r_en_d    = 1'b0;
      w_en_d    = 1'b0;
      cpu_ack_d = 1'b0;
      dbg_ack_d = 1'b0;
      cpu_rd_d  = cpu_rd_q;
      dbg_rd_d  = dbg_rd_q;
      unique case (state_q)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               owner_d = gnt_dbg;
               we_d    = gnt_dbg ? dbg_we    : cpu_we;
               addr_d  = gnt_dbg ? dbg_addr  : cpu_addr;
               wdata_d = gnt_dbg ? dbg_wdata : cpu_wdata;
               r_en_d  = ~we_d;
               w_en_d  = we_d;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            cpu_ack_d = ~owner_q;
            dbg_ack_d = owner_q;
            state_d   = RESP;
         end
         RESP: begin
            if (!we_q) begin
               if (owner_q) dbg_rd_d = ram_rdata;
               else         cpu_rd_d = ram_rdata;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         r_en_q    <= 1'b0;
         w_en_q    <= 1'b0;
         cpu_ack_q <= 1'b0;
         dbg_ack_q <= 1'b0;
         cpu_rd_q  <= '0;
         dbg_rd_q  <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         r_en_q    <= r_en_d;
         w_en_q    <= w_en_d;
         cpu_ack_q <= cpu_ack_d;
         dbg_ack_q <= dbg_ack_d;
         cpu_rd_q  <= cpu_rd_d;
         dbg_rd_q  <= dbg_rd_d;
      end
   end

   // RAM data arrives during RESP, so read data bypasses the holding register
   assign cpu_rdata = (cpu_ack_q && !we_q) ? ram_rdata : cpu_rd_q;
   assign dbg_rdata = (dbg_ack_q && !we_q) ? ram_rdata : dbg_rd_q;
   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_r_en  = r_en_q;
   assign ram_w_en  = w_en_q;
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single synchronous RAM port between two requesters: the CPU memory path (MAR/MDR side) and a debug/loader port used to preload or inspect memory.
- Each access is sequenced as a request/acknowledge transaction: latch, drive the RAM for one cycle, return data.
- Sits between the requesters and the RAM block.
- Fair round-robin arbitration; one access in flight at a time.

Parameters:
- ADDR_W, 8, RAM address width (256 words).
- DATA_W, 16, RAM word width.

Ports:
- clk  in  1  system clock (one-shot clock domain); all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack, held afterwards.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as cpu_* for the debug requester.
- ram_addr  out  ADDR_W  RAM address.
- ram_r_en  out  1  RAM read enable; RAM returns data the next cycle.
- ram_w_en  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_r_en.
- busy  out  1  high in ACCESS and RESP.
- owner  out  1  current or last grant: 0 = CPU, 1 = debug.

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-transaction included):
  - State goes to IDLE.
  - ram_r_en = ram_w_en = 0; ram_addr = 0; ram_wdata = 0.
  - cpu_ack = dbg_ack = 0; cpu_rdata = dbg_rdata = 0.
  - busy = 0; owner = 1 (so the CPU wins the first tie).
  - Any in-flight access is abandoned; no ack is issued for it.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both req high: grant the requester opposite to owner (round-robin).
  - On grant: latch we, addr and wdata of the winner into internal snapshot registers; set owner; go to ACCESS.
- ACCESS, exactly one cycle:
  - Drive ram_addr and ram_wdata from the snapshot.
  - Assert ram_r_en if snapshot we = 0, else ram_w_en. Never assert both.
  - Go to RESP.
- RESP, exactly one cycle:
  - Pulse the owner's ack.
  - If it was a read, load ram_rdata into the owner's rdata register.
  - Writes leave rdata unchanged.
  - Non-owner rdata is always unchanged.
  - Go to IDLE.
- Timing:
  - Latency is req sampled in IDLE (cycle 0) -> RAM enable in cycle 1 -> ack in cycle 2.
  - Throughput is at most one access per 3 cycles.
- RAM enables and acks are registered outputs, low outside ACCESS and RESP respectively.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until ack.
  - Changes after the grant cycle are ignored because of the snapshot.
  - req still high in the cycle after ack (IDLE) is a new request and is arbitrated normally.
  - With both requesters held high, grants alternate CPU, debug, CPU, ...
  - req dropped before ack: the latched access still completes and ack still pulses.
- No address arithmetic: addr passes through unmodified (width ADDR_W).

Test Plan:
- RAM[0x05] = 0x1234, cpu_req with we = 0, addr 0x05 at cycle 0 -> ram_r_en = 1 and ram_addr = 0x05 in cycle 1; cpu_ack = 1 and cpu_rdata = 0x1234 in cycle 2; ack low in cycle 3.
- dbg write addr 0x10, data 0xBEEF, then CPU read 0x10 -> ram_w_en pulses once; later cpu_rdata = 0xBEEF; dbg_rdata unchanged.
- Both req asserted and held from the cycle after reset, 4 reads of distinct addresses -> grant order CPU, dbg, CPU, dbg; acks 3 cycles apart; owner toggles 0, 1, 0, 1.
- Reset asserted mid-cycle during ACCESS of a write -> ram_w_en drops before the next edge; no ack; owner = 1, busy = 0; RAM content at that address unchanged if reset precedes the edge.
- CPU write of 0x00FF after a read of 0xAAAA -> cpu_rdata stays 0xAAAA after the write ack.
- cpu_req deasserted in cycle 1 after a read grant -> access completes; cpu_ack still pulses in cycle 2 with the RAM data.
